// File: rtl/input_encoder.sv
// input_encoder: synchronises and debounces 14 push-buttons, then emits one command code per press,
// lowest index first. Define INPUT_ENCODER_AUTOREPEAT_EN to add auto-repeat on movement keys 7..10.
module input_encoder #(
   parameter int DB_TICK      = 50000,
   parameter int DB_SAMPLES   = 4,
   parameter int REPEAT_DELAY = 32,
   parameter int REPEAT_RATE  = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [13:0] keys,
   output logic [3:0]  outCode,
   output logic        codeValid
);

   localparam int         NKEYS     = 14;
   localparam int         TICK_W    = $clog2(DB_TICK);
   localparam logic [3:0] IDLE_CODE = 4'hF;

   if (DB_TICK < 2 || DB_SAMPLES < 2 || DB_SAMPLES > 8 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_params
      $error("input_encoder: parameter out of range");
   end

   logic [NKEYS-1:0]                 sync_p0, sync_p1;
   logic [TICK_W-1:0]                tick_cnt;
   logic                             tick;
   logic [NKEYS-1:0][DB_SAMPLES-1:0] hist, hist_next;
   logic [NKEYS-1:0]                 db_state, db_next, press, rep_set;
   logic [NKEYS-1:0]                 pending, pending_next, sel_mask;
   logic [3:0]                       sel_code;
   logic                             sel_vld;

   // Stage p0/p1: two-flop synchroniser, the only reader of the raw buttons
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync_p0 <= '0;
         sync_p1 <= '0;
      end else begin
         sync_p0 <= keys;
         sync_p1 <= sync_p0;
      end
   end

   assign tick = (tick_cnt == TICK_W'(DB_TICK - 1));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         tick_cnt <= '0;
      end else if (tick) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + 1'b1;
      end
   end

   always_comb begin
      hist_next = hist;
      db_next   = db_state;
      if (tick) begin
         for (int i = 0; i < NKEYS; i++) begin
            hist_next[i] = {hist[i][DB_SAMPLES-2:0], sync_p1[i]};
            if (&hist_next[i]) begin
               db_next[i] = 1'b1;
            end else if (~|hist_next[i]) begin
               db_next[i] = 1'b0;
            end
         end
      end
   end

   assign press = db_next & ~db_state;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         hist     <= '0;
         db_state <= '0;
      end else begin
         hist     <= hist_next;
         db_state <= db_next;
      end
   end

`ifdef INPUT_ENCODER_AUTOREPEAT_EN
   localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int REP_W   = $clog2(REP_MAX + 1);

   logic [3:0]       rep_idx, rep_idx_q;
   logic             rep_held, rep_held_q, rep_armed, rep_fire, rep_restart;
   logic [REP_W-1:0] rep_cnt, rep_cnt_inc;

   always_comb begin
      rep_idx  = 4'd0;
      rep_held = 1'b0;
      for (int i = 10; i >= 7; i--) begin
         if (db_state[i]) begin
            rep_idx  = 4'(i);
            rep_held = 1'b1;
         end
      end
   end

   // The count only survives while the same movement key stays the lowest one held
   assign rep_restart = !rep_held || !rep_held_q || (rep_idx != rep_idx_q);
   assign rep_cnt_inc = rep_cnt + 1'b1;
   assign rep_fire    = tick && !rep_restart && db_next[rep_idx] &&
                        (rep_cnt_inc == (rep_armed ? REP_W'(REPEAT_RATE) : REP_W'(REPEAT_DELAY)));
   assign rep_set     = rep_fire ? (NKEYS'(1) << rep_idx) : '0;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rep_idx_q  <= 4'd0;
         rep_held_q <= 1'b0;
         rep_cnt    <= '0;
         rep_armed  <= 1'b0;
      end else begin
         rep_idx_q  <= rep_idx;
         rep_held_q <= rep_held;
         if (rep_restart) begin
            rep_cnt   <= '0;
            rep_armed <= 1'b0;
         end else if (rep_fire) begin
            rep_cnt   <= '0;
            rep_armed <= 1'b1;
         end else if (tick) begin
            rep_cnt   <= rep_cnt_inc;
         end
      end
   end
`else
   assign rep_set = '0;
`endif

   always_comb begin
      sel_vld  = 1'b0;
      sel_code = IDLE_CODE;
      for (int i = NKEYS - 1; i >= 0; i--) begin
         if (pending[i]) begin
            sel_vld  = 1'b1;
            sel_code = 4'(i);
         end
      end
   end

   // New presses are OR-ed in after the clear so a same-cycle re-press is not lost
   assign sel_mask     = sel_vld ? (NKEYS'(1) << sel_code) : '0;
   assign pending_next = (pending & ~sel_mask) | press | rep_set;

   // Stage p2: registered code/valid pair
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pending   <= '0;
         outCode   <= IDLE_CODE;
         codeValid <= 1'b0;
      end else begin
         pending   <= pending_next;
         outCode   <= sel_code;
         codeValid <= sel_vld;
      end
   end

endmodule

// File: doc/input_encoder.md
Name: input_encoder

Overview:
- Front end that produces the 4-bit command code stream consumed by the input decode stage.
- Samples 14 raw push-button lines, then synchronises and debounces each one.
- Converts each debounced press into a one-cycle command code on outCode.
- Presses that land in the same cycle are queued and emitted one per clock, lowest index first.
- Idle cycles carry IDLE_CODE, which downstream decode ignores.

Parameters:
- DB_TICK, 50000: clock cycles per debounce sample tick (≥2).
- DB_SAMPLES, 4: number of consecutive equal samples needed to change a key's debounced state (2..8).
- REPEAT_DELAY, 32: ticks a movement key must be held before the first auto-repeat. Used only with AUTOREPEAT_EN.
- REPEAT_RATE, 8: ticks between successive auto-repeats. Used only with AUTOREPEAT_EN.

Ports:
- clock, input, 1: system clock.
- reset, input, 1: asynchronous, active-low reset.
- keys, input, 14: raw buttons, active-high and asynchronous. keys[i] maps to command code i (0x0..0xD).
- outCode, output, 4: command code; equals IDLE_CODE (4'hF) when no event.
- codeValid, output, 1: high for exactly the cycles in which outCode carries a key code.

Behaviour:
- Reset (reset==0, asynchronous) clears:
  - sync flops, sample histories, debounced states, pending mask, tick counter.
  - outputs to outCode=4'hF, codeValid=0.
  - repeat counter (when AUTOREPEAT_EN is defined).
- Presses pending at reset are discarded. Events resume only after reset deasserts and a fresh debounce completes.
- Synchroniser: each keys bit passes through 2 flops. No other logic reads raw keys.
- Tick counter:
  - Counts 0..DB_TICK-1 and wraps to 0.
  - tick is high in the cycle where count==DB_TICK-1.
- Debounce, per key, on tick only:
  - Shift the synchronised value into a DB_SAMPLES-bit history.
  - History all ones → debounced state=1. All zeros → 0. Mixed → hold.
  - Between ticks the state is frozen.
- Press event: debounced state goes 0→1. Releases (1→0) produce nothing.
- Pending mask (14 bits):
  - A press event sets pending[i].
  - Every cycle with pending!=0, select the lowest set index i. Register outCode=i and codeValid=1 in the next cycle, and clear pending[i].
  - If the same bit is set and cleared in one cycle, set wins; the press is emitted again later.
  - If pending==0, register outCode=4'hF and codeValid=0.
- Latency: the press event is registered into pending at cycle N. outCode is valid at N+1 when no lower-index bit is pending.
  - Worst case from a clean raw edge: 2 + DB_TICK*DB_SAMPLES + 1 cycles.
- Simultaneous presses: emitted on consecutive cycles in ascending index order, with no idle cycle between them.
- Code 4'hE is never emitted. Code 4'hF appears only with codeValid=0.
- Holding a key produces exactly one code, except as described under Optional Feature.

Optional Feature:
- Macro: INPUT_ENCODER_AUTOREPEAT_EN.
- Defined: auto-repeat for movement keys 7..10 (codes 0x7..0xA).
  - The repeat key is the lowest-index movement key currently in debounced state 1.
  - One tick counter tracks the repeat key. It restarts at 0 whenever the repeat key's index changes or no movement key is held.
  - When the counter reaches REPEAT_DELAY, set pending for the repeat key. Thereafter set it every REPEAT_RATE ticks while held.
  - Repeats enter the same pending/priority path as presses.
  - Keys outside 7..10 never repeat.
- Undefined: no repeat logic is synthesised and behaviour is as above. Parameters REPEAT_DELAY and REPEAT_RATE are ignored.

Test Plan (DB_TICK=4, DB_SAMPLES=3):
- Reset: hold reset=0 with keys=14'h3FFF, then release. outCode=4'hF and codeValid=0 throughout reset. First codes are 0..13 in order, starting ≥12 cycles after release.
- Clean press: raise keys[5] and hold it for 200 cycles. Exactly one cycle shows outCode=4'h5 with codeValid=1, within 15 cycles. All other cycles show 4'hF.
- Bounce: toggle keys[2] every 3 cycles for 30 cycles, then hold high. Exactly one 4'h2 is emitted. Releasing with bounce emits nothing.
- Simultaneous: raise keys[9] and keys[3] in the same cycle. outCode shows 4'h3, then 4'h9 on the next cycle, both with codeValid=1, then 4'hF.
- Reset mid-operation: with keys[0], keys[4] and keys[12] pending, pulse reset=0 for 1 cycle with keys released before reset deasserts. No codes are emitted afterwards.
- INPUT_ENCODER_AUTOREPEAT_EN defined, REPEAT_DELAY=5, REPEAT_RATE=2: hold keys[7]. Expect 4'h7 at the press, again 5 ticks later, then every 2 ticks. Holding keys[1] yields a single 4'h1.
